// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the scan generator and the overlay
// generators (which reference H_ACTIVE / V_ACTIVE), plus small helpers.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned COLOR_W  = 6;
  localparam int unsigned COORD_W  = 10;

  // Per-pixel flags that must travel alongside the overlay pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_flags_t;

  // Half-open window test: lo <= c < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of DEPTH stages (DEPTH >= 1) with a loadable
// reset value. pre_o exposes the value about to enter the final stage so a
// caller can register something of its own in lockstep with that stage.
module sync_delay_line #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] pre_o,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  assign stage_d[0] = d_i;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_chain
      assign stage_d[gi] = stage_q[gi-1];
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Each stage loads its predecessor on an enabled clock, holds otherwise.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stage_q[gi] <= rst_val_i;
        end else if (en_i) begin
          stage_q[gi] <= stage_d[gi];
        end
      end
    end
  endgenerate

  assign pre_o = stage_d[DEPTH-1];
  assign q_o   = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: h/v counters, frame counter, raw syncs, and the
// final output stage that blanks the overlay colour and aligns the syncs
// with the overlay pipeline latency (PIPE_DELAY + 1 pixel strobes).
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP            = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP            = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP            = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP            = vga_timing_pkg::V_BP,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned PIPE_DELAY      = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pix_en,
  output logic [vga_timing_pkg::COORD_W-1:0]  x,
  output logic [vga_timing_pkg::COORD_W-1:0]  y,
  output logic                                active,
  output logic                                line_start,
  output logic                                frame_start,
  output logic [7:0]                          frame_count,
  input  logic [vga_timing_pkg::COLOR_W-1:0]  rgb_in,
  output logic [vga_timing_pkg::COLOR_W-1:0]  rgb_out,
  output logic                                hsync,
  output logic                                vsync
);
  import vga_timing_pkg::*;

  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // The output register below is the last alignment stage, so the line
  // carries PIPE_DELAY stages ahead of it plus that final stage.
  localparam int unsigned DLY_DEPTH = PIPE_DELAY + 1;

  logic [COORD_W-1:0] h_count_q, h_count_d;
  logic [COORD_W-1:0] v_count_q, v_count_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic [COLOR_W-1:0] rgb_out_q;

  scan_flags_t flags_now, flags_pre, flags_dly;
  logic        unused_pre_syncs;

  // Next-state for the raster counters; everything holds without pix_en.
  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        if (v_count_q == V_LAST) begin
          v_count_d     = '0;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          v_count_d = v_count_q + 10'd1;
        end
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= '0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = h_count_q;
  assign y           = v_count_q;
  assign frame_count = frame_count_q;
  assign active      = (h_count_q < H_VIS) && (v_count_q < V_VIS);
  assign line_start  = pix_en && (h_count_q == '0);
  assign frame_start = line_start && (v_count_q == '0);

  assign flags_now.active = active;
  assign flags_now.hs     = in_window(h_count_q, HS_LO, HS_HI);
  assign flags_now.vs     = in_window(v_count_q, VS_LO, VS_HI);

  sync_delay_line #(
    .W     ($bits(scan_flags_t)),
    .DEPTH (DLY_DEPTH)
  ) u_sync_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (pix_en),
    .rst_val_i ('0),
    .d_i       (flags_now),
    .pre_o     (flags_pre),
    .q_o       (flags_dly)
  );

  // The pre-final syncs are only needed one stage later via flags_dly.
  assign unused_pre_syncs = flags_pre.hs ^ flags_pre.vs;

  // Colour output register, clocked in step with the final sync stage so
  // the blanking decision uses the active flag of the same pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out_q <= '0;
    end else if (pix_en) begin
      rgb_out_q <= flags_pre.active ? rgb_in : '0;
    end
  end

  assign rgb_out = rgb_out_q;
  assign hsync   = flags_dly.hs ^ SYNC_ACTIVE_LOW;
  assign vsync   = flags_dly.vs ^ SYNC_ACTIVE_LOW;

endmodule
